// File: rtl/uart_transmitter_if.sv
// Byte handshake and serial-line bundle between a byte source and the UART transmitter.
interface uart_transmitter_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 ready;
  logic                 tx;
  logic                 done;

  modport master (output data, output valid, input ready, input tx, input done);
  modport slave  (input data, input valid, output ready, output tx, output done);
endinterface

// File: rtl/uart_transmitter.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, optional parity,
// STOP_BITS stop bits. Every bit boundary lands on a baud_rate_signal tick.
//
// state  | meaning
// IDLE   | line high, ready for a byte, ticks ignored
// ARMED  | byte latched, waiting for the first tick after acceptance
// START  | start bit (0) on the line
// DATA   | data bits on the line, shifting LSB first
// PARITY | parity bit on the line
// STOP   | stop bit(s) on the line; last stop tick pulses done
module uart_transmitter #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             baud_rate_signal,
  uart_transmitter_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARMED  = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } state_e;

  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic       LAST_STOP = (STOP_BITS == 2);
  localparam logic       ODD       = (PARITY_ODD != 0);
  localparam logic       PAR_ON    = (PARITY_EN != 0);

  state_e               state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 parity_q, parity_d;
  logic                 tx_q, tx_d;
  logic                 ready_q, ready_d;
  logic                 done_q, done_d;
  logic                 accept;

  assign accept    = bus.valid & ready_q;
  assign bus.tx    = tx_q;
  assign bus.ready = ready_q;
  assign bus.done  = done_q;

  // Next-state and registered-output decode; everything but acceptance waits for a tick.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    parity_d   = parity_q;
    tx_d       = tx_q;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (accept) begin
          shift_d = bus.data;
          state_d = ARMED;
        end
      end
      ARMED: begin
        if (baud_rate_signal) begin
          // Parity taken from the untouched latched byte before any shifting.
          parity_d = (^shift_q) ^ ODD;
          tx_d     = 1'b0;
          state_d  = START;
        end
      end
      START: begin
        if (baud_rate_signal) begin
          tx_d      = shift_q[0];
          bit_cnt_d = 3'd0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (baud_rate_signal) begin
          if (bit_cnt_q < LAST_BIT) begin
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
            bit_cnt_d = bit_cnt_q + 3'd1;
          end else if (PAR_ON) begin
            tx_d    = parity_q;
            state_d = PARITY;
          end else begin
            tx_d       = 1'b1;
            stop_cnt_d = 1'b0;
            state_d    = STOP;
          end
        end
      end
      PARITY: begin
        if (baud_rate_signal) begin
          tx_d       = 1'b1;
          stop_cnt_d = 1'b0;
          state_d    = STOP;
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (baud_rate_signal) begin
          if (stop_cnt_q == LAST_STOP) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
    ready_d = (state_d == IDLE);
  end

  // State and output registers; reset abandons any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= 3'd0;
      stop_cnt_q <= 1'b0;
      parity_q   <= 1'b0;
      tx_q       <= 1'b1;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      parity_q   <= parity_d;
      tx_q       <= tx_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
    end
  end

endmodule
